// File: rtl/demux_r.sv
// Routes a captured register value to a data-memory write strobe and/or a FWFT output queue.
// One request in flight at a time; requests arriving while busy are dropped and flagged.
module demux_r #(
  parameter int PROF_FILA = 4
) (
  input  logic       Clock,
  input  logic       Reset_N,
  input  logic [7:0] Dados_R,
  input  logic [1:0] SEL_Destino,
  input  logic       Escrever,
  input  logic [7:0] Endereco,
  output logic       Ocupado,
  output logic       WE_M,
  output logic [7:0] Endereco_M,
  output logic [7:0] Dados_M_W,
  output logic [7:0] Dados_OUT,
  output logic       OUT_Valid,
  input  logic       OUT_Ready,
  output logic [3:0] Nivel,
  output logic       Perdido
);

  localparam int         PW   = (PROF_FILA > 1) ? $clog2(PROF_FILA) : 1;
  localparam logic [3:0] FULL = 4'(PROF_FILA);

  typedef enum logic [1:0] {IDLE, MEM, FILA} state_t;

  state_t         state, state_nxt;
  logic [7:0]     cap_dat, cap_adr;
  logic [1:0]     cap_sel;
  logic           accept, push, pop, full;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [3:0]     count;
  logic [7:0]     fifo_mem [PROF_FILA];

  assign accept = (state == IDLE) && Escrever && (SEL_Destino != 2'b00);
  assign full   = (count == FULL);
  // Push decision uses occupancy at the start of the cycle, so a same-cycle pop cannot unblock it.
  assign push   = (state == FILA) && !full;
  assign pop    = OUT_Valid && OUT_Ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = SEL_Destino[0] ? MEM : FILA;
      MEM:  state_nxt = cap_sel[1] ? FILA : IDLE;
      FILA: if (!full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      cap_dat <= 8'h00;
      cap_adr <= 8'h00;
      cap_sel <= 2'b00;
    end else if (accept) begin
      cap_dat <= Dados_R;
      cap_adr <= Endereco;
      cap_sel <= SEL_Destino;
    end
  end

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      Perdido <= 1'b0;
    end else if (Escrever && (state != IDLE)) begin
      Perdido <= 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (push) fifo_mem[wr_ptr] <= cap_dat;
  end

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 4'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  assign Ocupado    = (state != IDLE);
  assign WE_M       = (state == MEM);
  assign Endereco_M = cap_adr;
  assign Dados_M_W  = cap_dat;
  assign Nivel      = count;
  assign OUT_Valid  = (count != 4'd0);
  assign Dados_OUT  = OUT_Valid ? fifo_mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_demux_r.sv
// Directed bench for demux_r: vector table for single transactions plus queue/reset sequences.
module tb_demux_r;

  logic       Clock = 1'b0;
  logic       Reset_N;
  logic [7:0] Dados_R;
  logic [1:0] SEL_Destino;
  logic       Escrever;
  logic [7:0] Endereco;
  logic       Ocupado;
  logic       WE_M;
  logic [7:0] Endereco_M;
  logic [7:0] Dados_M_W;
  logic [7:0] Dados_OUT;
  logic       OUT_Valid;
  logic       OUT_Ready;
  logic [3:0] Nivel;
  logic       Perdido;

  int compared = 0;
  int mismatched = 0;

  demux_r #(.PROF_FILA(4)) dut (
    .Clock(Clock), .Reset_N(Reset_N), .Dados_R(Dados_R), .SEL_Destino(SEL_Destino),
    .Escrever(Escrever), .Endereco(Endereco), .Ocupado(Ocupado), .WE_M(WE_M),
    .Endereco_M(Endereco_M), .Dados_M_W(Dados_M_W), .Dados_OUT(Dados_OUT),
    .OUT_Valid(OUT_Valid), .OUT_Ready(OUT_Ready), .Nivel(Nivel), .Perdido(Perdido)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       esc;
    logic [1:0] sel;
    logic [7:0] dr;
    logic [7:0] adr;
    logic       rdy;
    logic       we;
    logic [7:0] adr_m;
    logic [7:0] dat_m;
    logic       ocup;
    logic       valid;
    logic [7:0] dout;
    logic [3:0] niv;
    logic       perd;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (Ocupado && n < 20) begin
      tick();
      n++;
    end
    chk(nm, Ocupado, 0);
  endtask

  task automatic request(input logic [1:0] sel, input logic [7:0] dr, input logic [7:0] adr);
    Escrever = 1'b1; SEL_Destino = sel; Dados_R = dr; Endereco = adr;
    tick();
    Escrever = 1'b0;
  endtask

  initial begin
    logic [7:0] got [$];
    int maxn;
    int k;

    //          esc sel    dr     adr    rdy  we adr_m  dat_m  oc va dout   niv  perd
    vecs[0]  = '{1'b1, 2'b01, 8'h5A, 8'h10, 1'b0, 1'b1, 8'h10, 8'h5A, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0};
    vecs[1]  = '{1'b0, 2'b01, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h10, 8'h5A, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0};
    vecs[2]  = '{1'b1, 2'b11, 8'hC3, 8'h20, 1'b1, 1'b1, 8'h20, 8'hC3, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0};
    vecs[3]  = '{1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'hC3, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0};
    vecs[4]  = '{1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'hC3, 1'b0, 1'b1, 8'hC3, 4'd1, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'hC3, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0};
    vecs[6]  = '{1'b1, 2'b00, 8'hEE, 8'hEE, 1'b0, 1'b0, 8'h20, 8'hC3, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0};
    vecs[7]  = '{1'b1, 2'b10, 8'h77, 8'h33, 1'b0, 1'b0, 8'h33, 8'h77, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0};
    vecs[8]  = '{1'b0, 2'b10, 8'h00, 8'h00, 1'b0, 1'b0, 8'h33, 8'h77, 1'b0, 1'b1, 8'h77, 4'd1, 1'b0};
    vecs[9]  = '{1'b0, 2'b10, 8'h00, 8'h00, 1'b0, 1'b0, 8'h33, 8'h77, 1'b0, 1'b1, 8'h77, 4'd1, 1'b0};
    vecs[10] = '{1'b0, 2'b10, 8'h00, 8'h00, 1'b1, 1'b0, 8'h33, 8'h77, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0};

    Reset_N = 1'b0; Dados_R = 8'h00; SEL_Destino = 2'b00; Escrever = 1'b0;
    Endereco = 8'h00; OUT_Ready = 1'b0;
    #2;
    chk("rst ocup", Ocupado, 0);
    chk("rst we", WE_M, 0);
    chk("rst adr_m", Endereco_M, 8'h00);
    chk("rst dat_m", Dados_M_W, 8'h00);
    chk("rst valid", OUT_Valid, 0);
    chk("rst dout", Dados_OUT, 8'h00);
    chk("rst niv", Nivel, 0);
    chk("rst perd", Perdido, 0);
    tick(); tick();
    Reset_N = 1'b1;

    for (int i = 0; i < 11; i++) begin
      Escrever = vecs[i].esc; SEL_Destino = vecs[i].sel; Dados_R = vecs[i].dr;
      Endereco = vecs[i].adr; OUT_Ready = vecs[i].rdy;
      tick();
      chk($sformatf("v%0d we", i), WE_M, vecs[i].we);
      chk($sformatf("v%0d adr_m", i), Endereco_M, vecs[i].adr_m);
      chk($sformatf("v%0d dat_m", i), Dados_M_W, vecs[i].dat_m);
      chk($sformatf("v%0d ocup", i), Ocupado, vecs[i].ocup);
      chk($sformatf("v%0d valid", i), OUT_Valid, vecs[i].valid);
      chk($sformatf("v%0d dout", i), Dados_OUT, vecs[i].dout);
      chk($sformatf("v%0d niv", i), Nivel, vecs[i].niv);
      chk($sformatf("v%0d perd", i), Perdido, vecs[i].perd);
    end
    Escrever = 1'b0;

    // Fill the queue with the consumer stalled, then drain it.
    OUT_Ready = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      request(2'b10, 8'(v), 8'h00);
      wait_idle($sformatf("fill%0d idle", v));
    end
    chk("full niv", Nivel, 4);
    request(2'b10, 8'h05, 8'h00);
    tick(); tick(); tick();
    chk("stall ocup", Ocupado, 1);
    chk("stall niv", Nivel, 4);
    chk("stall head", Dados_OUT, 8'h01);
    OUT_Ready = 1'b1;
    got.delete();
    for (int c = 0; c < 20 && got.size() < 5; c++) begin
      if (OUT_Valid) got.push_back(Dados_OUT);
      tick();
      if (c == 0) begin
        chk("pop1 ocup", Ocupado, 1);
        chk("pop1 niv", Nivel, 3);
      end
      if (c == 1) begin
        chk("push5 ocup", Ocupado, 0);
        chk("push5 niv", Nivel, 3);
      end
    end
    chk("drain count", got.size(), 5);
    for (int v = 0; v < 5; v++)
      if (v < got.size()) chk($sformatf("drain[%0d]", v), got[v], 8'(v + 1));
    tick();
    chk("drain empty", Nivel, 0);

    // Request while busy is dropped and flagged.
    wait_idle("busy pre idle");
    request(2'b01, 8'hAA, 8'h40);
    Escrever = 1'b1; SEL_Destino = 2'b10; Dados_R = 8'hBB; Endereco = 8'h50;
    tick();
    Escrever = 1'b0;
    chk("busy perd", Perdido, 1);
    chk("busy dat_m", Dados_M_W, 8'hAA);
    chk("busy adr_m", Endereco_M, 8'h40);
    chk("busy ocup", Ocupado, 0);
    chk("busy niv", Nivel, 0);
    request(2'b10, 8'h11, 8'h00);
    wait_idle("busy post idle");
    tick();
    chk("perd sticky", Perdido, 1);

    // Reset in MEM with two entries queued.
    OUT_Ready = 1'b0;
    request(2'b10, 8'h21, 8'h00);
    wait_idle("r1 idle");
    request(2'b10, 8'h22, 8'h00);
    wait_idle("r2 idle");
    chk("pre-rst niv", Nivel, 2);
    request(2'b11, 8'h99, 8'h55);
    chk("pre-rst we", WE_M, 1);
    Reset_N = 1'b0;
    #1;
    chk("mid-rst we", WE_M, 0);
    chk("mid-rst niv", Nivel, 0);
    chk("mid-rst valid", OUT_Valid, 0);
    chk("mid-rst ocup", Ocupado, 0);
    chk("mid-rst perd", Perdido, 0);
    chk("mid-rst dat_m", Dados_M_W, 8'h00);
    tick(); tick();
    Reset_N = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("post-rst%0d we", c), WE_M, 0);
      chk($sformatf("post-rst%0d valid", c), OUT_Valid, 0);
    end
    request(2'b01, 8'h3C, 8'h4D);
    chk("first req we", WE_M, 1);
    chk("first req dat", Dados_M_W, 8'h3C);
    wait_idle("first req idle");

    // Back-to-back requests with the consumer always ready.
    OUT_Ready = 1'b1;
    got.delete();
    maxn = 0;
    k = 0;
    for (int c = 0; c < 80 && got.size() < 10; c++) begin
      if (OUT_Valid) got.push_back(Dados_OUT);
      if (int'(Nivel) > maxn) maxn = int'(Nivel);
      if (!Ocupado && k < 10) begin
        Escrever = 1'b1; SEL_Destino = 2'b10; Dados_R = 8'(8'h80 + k);
        k++;
      end else begin
        Escrever = 1'b0;
      end
      tick();
    end
    Escrever = 1'b0;
    chk("stream count", got.size(), 10);
    chk("stream max niv", maxn, 1);
    for (int v = 0; v < 10; v++)
      if (v < got.size()) chk($sformatf("stream[%0d]", v), got[v], 8'(8'h80 + v));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/demux_r.md
DEMUX_R -- requirements
Module: Demux_R

Interface
REQ-001 Parameter PROF_FILA, default 4, sets the output-queue depth in entries; legal values are 2, 4 and 8.
REQ-002 Clock  in  1  single system clock; all state changes on its rising edge.
REQ-003 Reset_N  in  1  asynchronous, active-low reset.
REQ-004 Dados_R  in  8  current value of register R to be delivered.
REQ-005 SEL_Destino  in  2  destination select: 00 none, 01 memory, 10 output port, 11 memory then output port.
REQ-006 Escrever  in  1  one-cycle write request, sampled on the rising edge.
REQ-007 Endereco  in  8  data-memory address for the request.
REQ-008 Ocupado  out  1  high whenever the FSM is not in IDLE.
REQ-009 WE_M  out  1  data-memory write strobe.
REQ-010 Endereco_M  out  8  captured memory address.
REQ-011 Dados_M_W  out  8  captured memory write data.
REQ-012 Dados_OUT  out  8  output-port data, taken from the queue head.
REQ-013 OUT_Valid  out  1  output-port data valid.
REQ-014 OUT_Ready  in  1  output-port consumer ready.
REQ-015 Nivel  out  4  queue occupancy, 0..PROF_FILA.
REQ-016 Perdido  out  1  sticky flag: a request was dropped.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, MEM and FILA; Ocupado SHALL equal (state != IDLE).
REQ-018 In IDLE, an edge with Escrever=1 and SEL_Destino!=00 SHALL capture Dados_R, Endereco and SEL_Destino into internal registers; the next state SHALL be MEM if SEL_Destino[0]=1, otherwise FILA.
REQ-019 In IDLE, an edge with Escrever=1 and SEL_Destino=00 SHALL be a no-op: the FSM stays in IDLE and Perdido is unchanged.
REQ-020 In MEM, WE_M SHALL be 1 for exactly that one cycle, with Endereco_M and Dados_M_W driven from the captured registers; the next state SHALL be FILA if captured SEL[1]=1, otherwise IDLE.
REQ-021 Outside MEM, WE_M SHALL be 0; Endereco_M and Dados_M_W SHALL hold their last captured values.
REQ-022 In FILA, if Nivel < PROF_FILA at the start of the cycle, the captured data SHALL be pushed at the closing edge and the next state SHALL be IDLE; otherwise the FSM SHALL stay in FILA (stall) with no push.
REQ-023 A pop occurring in the same cycle as a full-queue stall SHALL NOT enable the push in that cycle; the push SHALL occur on the following cycle.
REQ-024 An edge with Escrever=1 while Ocupado=1 SHALL be ignored (no capture) and SHALL set Perdido=1; Perdido SHALL clear only on reset.
REQ-025 The queue SHALL be first-word-fall-through: OUT_Valid=(Nivel!=0); Dados_OUT SHALL be the head entry, or 0x00 when the queue is empty.
REQ-026 A pop SHALL occur on each edge where OUT_Valid=1 and OUT_Ready=1.
REQ-027 Simultaneous push and pop SHALL leave Nivel unchanged and preserve FIFO order.
REQ-028 Read and write pointers SHALL wrap modulo PROF_FILA.
REQ-029 Latency: Escrever at edge N with SEL=01 gives WE_M=1 in cycle N+1; with SEL=10, OUT_Valid=1 from cycle N+2 if the queue was empty; with SEL=11, WE_M=1 in cycle N+1 and OUT_Valid=1 from cycle N+3.
REQ-030 Data captured at the request edge SHALL be the value delivered, regardless of later changes to Dados_R or Endereco.

Reset
REQ-031 Reset_N=0 SHALL immediately force: state IDLE, Ocupado=0, WE_M=0, Endereco_M=0x00, Dados_M_W=0x00, queue empty (Nivel=0, OUT_Valid=0, Dados_OUT=0x00), Perdido=0, pointers=0.
REQ-032 Reset asserted mid-operation SHALL abandon any pending request and discard all queue contents; no WE_M pulse SHALL follow deassertion.
REQ-033 After deassertion, the first edge SHALL be able to accept a request.

Verification
REQ-034 Dados_R=0x5A, Endereco=0x10, SEL=01, Escrever pulse -> exactly one cycle with WE_M=1, Endereco_M=0x10, Dados_M_W=0x5A; no change to OUT_Valid.
REQ-035 SEL=11, Dados_R=0xC3, OUT_Ready=1 -> WE_M pulse in cycle N+1, OUT_Valid=1 with Dados_OUT=0xC3 in cycle N+3, popped at the end of that cycle, then Nivel=0.
REQ-036 OUT_Ready=0; five SEL=10 requests of 0x01..0x05 spaced by Ocupado=0 -> Nivel=4 and the fifth request stalls in FILA; raise OUT_Ready -> output order 0x01..0x05; push of 0x05 occurs one cycle after the first pop.
REQ-037 Escrever pulsed while Ocupado=1 -> request ignored, Perdido=1 and stays 1 through later traffic until Reset_N=0.
REQ-038 Reset_N pulled low during MEM with 2 queue entries -> WE_M=0 and Nivel=0 immediately; after release, no spurious WE_M and OUT_Valid=0.
REQ-039 Steady OUT_Ready=1 with back-to-back SEL=10 requests -> Nivel never exceeds 1, pointers wrap past PROF_FILA, and data order is preserved across 10 requests.
